// File: rtl/fifo_axis_pkt_pkg.sv
// Shared constants and width helpers for the AXI-Stream packet FIFO.
package fifo_pkg;

  localparam string MODE_SF = "true";
  localparam string MODE_CT = "false";

  localparam int STAT_W = 32;

  // Pointer and level width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_axis_pkt_mem.sv
// Dual-pointer circular buffer with wrap-bit full/empty detection and level.
module fifo_axis_pkt_mem
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int W     = 513,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] level_o
);

  localparam int IDX_W = PTR_W - 1;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [W-1:0] mem_q [DEPTH];
  ptr_t         wr_ptr_q;
  ptr_t         rd_ptr_q;

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fifo_axis_pkt.sv
// AXI-Stream FIFO, cut-through or packet store-and-forward with oversize bypass.
// Optional packet statistics counters are enabled by defining FIFO_AXIS_PKT_STATS_EN.
module fifo_axis_pkt
  import fifo_pkg::*;
#(
  parameter  int    FIFO_DEPTH      = 64,
  parameter  int    FIFO_W          = 512,
  parameter  string PKT_MODE        = "true",
  parameter  int    ALMOST_FULL_THR = 8,
  localparam int    LVL_W           = ptr_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FIFO_W-1:0] axis_data_i,
  input  logic              axis_valid_i,
  input  logic              axis_last_i,
  output logic              axis_ready_o,
  output logic [FIFO_W-1:0] axis_data_o,
  output logic              axis_valid_o,
  output logic              axis_last_o,
  input  logic              axis_ready_i,
  output logic [LVL_W-1:0]  level_o,
  output logic              almost_full_o,
  output logic [LVL_W-1:0]  pkt_cnt_o,
  output logic              oversize_o,
  output logic [STAT_W-1:0] stat_pkt_in_o,
  output logic [STAT_W-1:0] stat_pkt_out_o
);

  localparam bit PKT_EN = (PKT_MODE == MODE_SF);

  typedef logic [LVL_W-1:0] lvl_t;

  logic        full, empty, wr_fire, rd_fire, wr_last, rd_last, bypass_q, valid;
  logic [FIFO_W:0] rd_beat;
  lvl_t        level, free, pkt_cnt_q, pkt_cnt_d;

  fifo_axis_pkt_mem #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W + 1)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_fire),
    .wr_data_i ({axis_last_i, axis_data_i}),
    .rd_en_i   (rd_fire),
    .rd_data_o (rd_beat),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level)
  );

  assign valid   = PKT_EN ? (!empty && (pkt_cnt_q != '0 || bypass_q)) : !empty;
  assign wr_fire = axis_valid_i && !full;
  assign rd_fire = valid && axis_ready_i;
  assign wr_last = wr_fire && axis_last_i;
  assign rd_last = rd_fire && rd_beat[FIFO_W];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (wr_last && !rd_last)      pkt_cnt_d = pkt_cnt_q + lvl_t'(1);
    else if (rd_last && !wr_last) pkt_cnt_d = pkt_cnt_q - lvl_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  if (PKT_EN) begin : g_bypass
    logic trigger, bypass_d, oversize_q;

    // A full buffer with no complete packet can never complete one: drain it cut-through.
    assign trigger = full && (pkt_cnt_q == '0) && !bypass_q;

    always_comb begin
      bypass_d = bypass_q;
      if (trigger)                 bypass_d = 1'b1;
      else if (bypass_q && wr_last) bypass_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bypass_q   <= 1'b0;
        oversize_q <= 1'b0;
      end else begin
        bypass_q   <= bypass_d;
        oversize_q <= trigger;
      end
    end

    assign oversize_o = oversize_q;
  end else begin : g_no_bypass
    assign bypass_q   = 1'b0;
    assign oversize_o = 1'b0;
  end

`ifdef FIFO_AXIS_PKT_STATS_EN
  logic [STAT_W-1:0] stat_in_q, stat_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      if (wr_last) stat_in_q  <= stat_in_q + STAT_W'(1);
      if (rd_last) stat_out_q <= stat_out_q + STAT_W'(1);
    end
  end

  assign stat_pkt_in_o  = stat_in_q;
  assign stat_pkt_out_o = stat_out_q;
`else
  assign stat_pkt_in_o  = '0;
  assign stat_pkt_out_o = '0;
`endif

  assign free          = lvl_t'(FIFO_DEPTH) - level;
  assign axis_ready_o  = !full;
  assign axis_valid_o  = valid;
  assign axis_data_o   = valid ? rd_beat[FIFO_W-1:0] : '0;
  assign axis_last_o   = valid && rd_beat[FIFO_W];
  assign level_o       = level;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign almost_full_o = (int'(free) <= ALMOST_FULL_THR);

endmodule
